ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard on the same PS2_CLK/PS2_DATA pair the keyboard decoder listens on. Runs the request-to-send inhibit, shifts 8 data bits plus odd parity and stop on device-generated clock edges, and checks the device ACK bit. Sits beside the keyboard decoder in the top level, which owns the open-drain tri-state buffers. While a frame is in flight, `tx_busy` gates the decoder's `key_valid`.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_host_tx_if.sv | 24 ++
 rtl/ps2_sync_edge.sv | 40 ++++
 rtl/ps2_host_tx.sv | 200 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 host transmitter and the keyboard
// decoder that sits next to it.
//   ps2_tx_state_e : host transmit FSM states
//   PS2_CMD_* / PS2_RESP_* : common command and response bytes
//   odd_parity()   : PS/2 parity bit for a data byte
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_RTS     = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_ACK     = 3'd4,
    ST_RELEASE = 3'd5
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_RESP_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESP_RESEND = 8'hFE;

  // The parity bit makes the count of ones over data + parity odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if -- command handshake between a requester and ps2_host_tx.
//   tx_valid/tx_data : request to send one byte
//   tx_ready         : transmitter idle, byte accepted on tx_valid && tx_ready
//   tx_busy          : frame in flight
//   tx_done/tx_err   : one-cycle completion pulses
// master = requester side, slave = transmitter side.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx_busy, tx_done, tx_err
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx_busy, tx_done, tx_err
  );
endinterface

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge -- brings the raw PS/2 clock and data lines into the clk
// domain and flags falling edges of the PS/2 clock.
//   clk, rst               : system clock, synchronous active-high reset
//   ps2_clk_in, ps2_data_in: asynchronous line levels
//   clk_s, data_s          : 2-FF synchronized levels
//   clk_fe                 : high for one cycle after clk_s goes 1->0
// Reset value of the synchronizers is 1 (idle bus, lines pulled up) so that
// leaving reset never fakes an edge.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_s,
  output logic data_s,
  output logic clk_fe
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_ff  <= 2'b11;
      data_ff <= 2'b11;
      clk_d   <= 1'b1;
    end else begin
      clk_ff  <= {clk_ff[0], ps2_clk_in};
      data_ff <= {data_ff[0], ps2_data_in};
      clk_d   <= clk_ff[1];
    end
  end

  assign clk_s  = clk_ff[1];
  assign data_s = data_ff[1];
  // Edge built from two flops only, so the FSM can react on the next edge.
  assign clk_fe = clk_d & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 transmitter. Sends one command byte to
// the keyboard: request-to-send inhibit, 8 data bits + odd parity + stop on
// device clock falling edges, then the device ACK bit.
//   clk, rst                   : system clock, synchronous active-high reset
//   tx (ps2_host_tx_if.slave)  : tx_valid/tx_data/tx_ready/tx_busy/tx_done/tx_err
//   ps2_clk_in, ps2_data_in    : raw line levels (asynchronous)
//   ps2_clk_low, ps2_data_low  : 1 = pull the line to 0, 0 = release it
// Parameters: INHIBIT_CYC (clock-low time before RTS), TIMEOUT_CYC (RTS to
// end-of-frame limit).
// Build option: define PS2_TX_ACK_CHECK_EN to sample the device ACK bit and
// report a NACK as tx_err; otherwise the 11th clock is only waited for and
// every completed frame reports tx_done.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | lines released, tx_ready high
// ST_INHIBIT | PS2_CLK held low INHIBIT_CYC cycles, data pulled low last
// ST_RTS     | clock released, start bit on data, waiting 1st device edge
// ST_SHIFT   | d1..d7, parity, stop driven on successive falling edges
// ST_ACK     | waiting 11th edge to sample the device ACK bit
// ST_RELEASE | waiting for both lines high, then done/err pulse
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = 10000,
  parameter int TIMEOUT_CYC = 1500000
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  tx,
  input  logic          ps2_clk_in,
  input  logic          ps2_data_in,
  output logic          ps2_clk_low,
  output logic          ps2_data_low
);

  localparam int INH_W = $clog2(INHIBIT_CYC + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

  ps2_tx_state_e state, state_nxt;
  logic [INH_W-1:0] inh_cnt, inh_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
  logic [9:0]       shreg, sh_nxt;   // {stop, parity, d7..d0}, LSB goes out first
  logic [3:0]       bit_idx, idx_nxt;
  logic             ack_ok, ack_ok_nxt;
  logic             ack_edge, ack_edge_nxt;  // 11th falling edge already seen
  logic             clk_low_nxt, data_low_nxt;
  logic             ready_nxt, busy_nxt, done_nxt, err_nxt;
  logic             clk_s, data_s, clk_fe;
  logic             accept, timed;

  ps2_sync_edge u_sync (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_s       (clk_s),
    .data_s      (data_s),
    .clk_fe      (clk_fe)
  );

  assign accept = tx.tx_valid && tx.tx_ready;
  assign timed  = (state == ST_RTS) || (state == ST_SHIFT) ||
                  (state == ST_ACK) || (state == ST_RELEASE);

  always_comb begin
    state_nxt    = state;
    inh_nxt      = inh_cnt;
    tmo_nxt      = tmo_cnt;
    sh_nxt       = shreg;
    idx_nxt      = bit_idx;
    ack_ok_nxt   = ack_ok;
    ack_edge_nxt = ack_edge;
    clk_low_nxt  = ps2_clk_low;
    data_low_nxt = ps2_data_low;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;

    if (timed && (tmo_cnt == '0)) begin
      // Timeout wins over any edge arriving in the same cycle.
      state_nxt    = ST_IDLE;
      clk_low_nxt  = 1'b0;
      data_low_nxt = 1'b0;
      err_nxt      = 1'b1;
    end else begin
      if (timed) tmo_nxt = tmo_cnt - TMO_W'(1);
      case (state)
        ST_IDLE: begin
          clk_low_nxt  = 1'b0;
          data_low_nxt = 1'b0;
          if (accept) begin
            state_nxt    = ST_INHIBIT;
            clk_low_nxt  = 1'b1;
            data_low_nxt = (INH_LOAD == '0);
            inh_nxt      = INH_LOAD;
            sh_nxt       = {1'b1, odd_parity(tx.tx_data), tx.tx_data};
            ack_ok_nxt   = 1'b1;
            ack_edge_nxt = 1'b0;
          end
        end
        ST_INHIBIT: begin
          if (inh_cnt == '0) begin
            state_nxt    = ST_RTS;
            clk_low_nxt  = 1'b0;
            data_low_nxt = 1'b1;
            tmo_nxt      = TMO_LOAD;
          end else begin
            inh_nxt      = inh_cnt - INH_W'(1);
            data_low_nxt = (inh_cnt == INH_W'(1));
          end
        end
        ST_RTS: begin
          if (clk_fe) begin
            state_nxt    = ST_SHIFT;
            data_low_nxt = ~shreg[0];
            sh_nxt       = {1'b0, shreg[9:1]};
            idx_nxt      = 4'd1;
          end
        end
        ST_SHIFT: begin
          if (clk_fe) begin
            data_low_nxt = ~shreg[0];
            sh_nxt       = {1'b0, shreg[9:1]};
            idx_nxt      = bit_idx + 4'd1;
            // bit_idx 9 is the stop bit: data is released on this edge.
            if (bit_idx == 4'd9) begin
`ifdef PS2_TX_ACK_CHECK_EN
              state_nxt = ST_ACK;
`else
              state_nxt = ST_RELEASE;
`endif
            end
          end
        end
`ifdef PS2_TX_ACK_CHECK_EN
        ST_ACK: begin
          if (clk_fe) begin
            state_nxt    = ST_RELEASE;
            ack_ok_nxt   = ~data_s;
            ack_edge_nxt = 1'b1;
          end
        end
`endif
        ST_RELEASE: begin
          if (!ack_edge) begin
            if (clk_fe) ack_edge_nxt = 1'b1;
          end else if (clk_s && data_s) begin
            state_nxt = ST_IDLE;
            done_nxt  = ack_ok;
            err_nxt   = ~ack_ok;
          end
        end
        default: begin
          state_nxt    = ST_IDLE;
          clk_low_nxt  = 1'b0;
          data_low_nxt = 1'b0;
        end
      endcase
    end

    // tx_ready comes back one cycle after the done/err pulse.
    ready_nxt = (state == ST_IDLE) && (state_nxt == ST_IDLE);
    busy_nxt  = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      inh_cnt      <= '0;
      tmo_cnt      <= '0;
      shreg        <= '0;
      bit_idx      <= '0;
      ack_ok       <= 1'b0;
      ack_edge     <= 1'b0;
      ps2_clk_low  <= 1'b0;
      ps2_data_low <= 1'b0;
      tx.tx_ready  <= 1'b1;
      tx.tx_busy   <= 1'b0;
      tx.tx_done   <= 1'b0;
      tx.tx_err    <= 1'b0;
    end else begin
      state        <= state_nxt;
      inh_cnt      <= inh_nxt;
      tmo_cnt      <= tmo_nxt;
      shreg        <= sh_nxt;
      bit_idx      <= idx_nxt;
      ack_ok       <= ack_ok_nxt;
      ack_edge     <= ack_edge_nxt;
      ps2_clk_low  <= clk_low_nxt;
      ps2_data_low <= data_low_nxt;
      tx.tx_ready  <= ready_nxt;
      tx.tx_busy   <= busy_nxt;
      tx.tx_done   <= done_nxt;
      tx.tx_err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- bench for ps2_host_tx with a PS/2 device model clocking at
// a 40-cycle period. Build with or without PS2_TX_ACK_CHECK_EN.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_host_tx_if tx_if ();

  logic ps2_clk_low, ps2_data_low;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic dev_abort    = 1'b0;
  logic ps2_clk_line, ps2_data_line;
  assign ps2_clk_line  = !(ps2_clk_low || dev_clk_low);
  assign ps2_data_line = !(ps2_data_low || dev_data_low);

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .tx           (tx_if),
    .ps2_clk_in   (ps2_clk_line),
    .ps2_data_in  (ps2_data_line),
    .ps2_clk_low  (ps2_clk_low),
    .ps2_data_low (ps2_data_low)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;
  int n_err    = 0;
  int n_acc    = 0;

  task automatic check_eq(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected frame as the device sees it, bit k = k-th bit on the wire:
  // d0..d7, then parity making total ones odd, then stop = 1.
  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, ((ones % 2) == 0), b};
  endfunction

  // Per-cycle checker of the handshake and line rules.
  bit in_frame = 1'b0;
  bit acc_prev = 1'b0;
  int low_len  = 0;
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
      acc_prev = 1'b0;
      low_len  = 0;
    end else begin
      bit pulse;
      if (acc_prev) begin
        in_frame = 1'b1;
        check_eq("accept_to_clk_low", ps2_clk_low, 1);
      end
      pulse = tx_if.tx_done || tx_if.tx_err;
      check_eq("done_err_exclusive", tx_if.tx_done && tx_if.tx_err, 0);
      if (pulse) begin
        check_eq("pulse_in_frame", in_frame, 1);
        in_frame = 1'b0;
        if (tx_if.tx_done) n_done++;
        if (tx_if.tx_err) n_err++;
      end
      check_eq("busy", tx_if.tx_busy, in_frame);
      check_eq("ready", tx_if.tx_ready, !in_frame && !pulse);
      if (!in_frame) check_eq("idle_lines", {ps2_clk_low, ps2_data_low}, 0);
      if (ps2_clk_low) low_len++;
      else begin
        if (low_len != 0) check_eq("inhibit_len", low_len, INH);
        low_len = 0;
      end
      acc_prev = tx_if.tx_valid && tx_if.tx_ready;
      if (acc_prev) n_acc++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    int t = 0;
    @(posedge clk); #1;
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = b;
    while (!acc && t < 50) begin
      @(negedge clk);
      if (tx_if.tx_ready) acc = 1'b1;
      @(posedge clk); #1;
      t++;
    end
    tx_if.tx_valid = 1'b0;
    check_eq("accept", acc, 1);
  endtask

  task automatic dev_wait(input int n);
    for (int i = 0; i < n && !dev_abort; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Device side: waits for RTS, generates 11 clocks, samples 10 bits on the
  // rising edges, drives the ACK bit (low when ack_low) for the 11th clock.
  task automatic dev_receive(input bit ack_low, output logic [9:0] fr);
    int t = 0;
    fr = '0;
    while (!(ps2_clk_line && !ps2_data_line && !ps2_clk_low) && t < 200 && !dev_abort) begin
      @(posedge clk); #1;
      t++;
    end
    if (dev_abort) return;
    if (t >= 200) begin
      check_eq("rts_seen", 0, 1);
      return;
    end
    dev_wait(10);
    for (int k = 0; k < 11; k++) begin
      dev_clk_low = 1'b1;
      dev_wait(20);
      if (k < 10) fr[k] = ps2_data_line;
      dev_clk_low = 1'b0;
      if (k == 9) dev_data_low = ack_low;
      if (k == 10) dev_data_low = 1'b0;
      if (!dev_abort) dev_wait(20);
      if (dev_abort) begin
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        return;
      end
    end
  endtask

  task automatic frame_test(input logic [7:0] b, input bit ack_low, input bit exp_done,
                            input string tag, output logic [9:0] fr);
    int d0, e0, a0;
    d0 = n_done;
    e0 = n_err;
    a0 = n_acc;
    send_byte(b);
    dev_receive(ack_low, fr);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_frame"}, fr, exp_frame(b));
    check_eq({tag, "_done"}, n_done - d0, exp_done);
    check_eq({tag, "_err"}, n_err - e0, !exp_done);
    check_eq({tag, "_accepts"}, n_acc - a0, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_ready"}, tx_if.tx_ready, 1);
    check_eq({tag, "_busy"}, tx_if.tx_busy, 0);
    check_eq({tag, "_done"}, tx_if.tx_done, 0);
    check_eq({tag, "_err"}, tx_if.tx_err, 0);
    check_eq({tag, "_clk_low"}, ps2_clk_low, 0);
    check_eq({tag, "_data_low"}, ps2_data_low, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0] fr;
    bit nack_done;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Set-LEDs command, device ACKs: wire bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
    frame_test(8'hED, 1'b1, 1'b1, "ed_ack", fr);
    check_eq("ed_literal_frame", fr, 10'h3ED);

    // 0x00 with the device leaving ACK high.
`ifdef PS2_TX_ACK_CHECK_EN
    nack_done = 1'b0;
`else
    nack_done = 1'b1;
`endif
    frame_test(8'h00, 1'b0, nack_done, "zero_nack", fr);
    check_eq("zero_literal_frame", fr, 10'h300);

    // Device never clocks: error exactly TMO cycles after RTS.
    begin
      bit prev = 1'b0, found = 1'b0;
      int t = 0, cyc = 0, e0;
      e0 = n_err;
      send_byte(8'h3C);
      while (!found && t < 100) begin
        @(negedge clk);
        if (prev && !ps2_clk_low) found = 1'b1;
        prev = ps2_clk_low;
        t++;
      end
      check_eq("tmo_rts_found", found, 1);
      check_eq("tmo_start_bit", ps2_data_low, 1);
      do begin
        @(negedge clk);
        cyc++;
      end while (!tx_if.tx_err && cyc < 2500);
      check_eq("tmo_cycles", cyc, TMO);
      check_eq("tmo_err", tx_if.tx_err, 1);
      check_eq("tmo_clk_low", ps2_clk_low, 0);
      check_eq("tmo_data_low", ps2_data_low, 0);
      @(negedge clk);
      check_eq("tmo_ready_after", tx_if.tx_ready, 1);
      check_eq("tmo_err_count", n_err - e0, 1);
    end
    repeat (5) @(posedge clk);

    // Request during a frame in flight is ignored.
    begin
      int a0, d0;
      a0 = n_acc;
      d0 = n_done;
      fork
        frame_test(8'h5A, 1'b1, 1'b1, "overlap", fr);
        begin
          repeat (60) @(posedge clk);
          #1;
          tx_if.tx_valid = 1'b1;
          tx_if.tx_data  = 8'hFF;
          repeat (200) @(posedge clk);
          #1;
          tx_if.tx_valid = 1'b0;
        end
      join
      repeat (100) @(posedge clk);
      @(negedge clk);
      check_eq("overlap_single_accept", n_acc - a0, 1);
      check_eq("overlap_single_done", n_done - d0, 1);
    end

    // Reset after the 4th device falling edge.
    send_byte(8'h96);
    fork
      dev_receive(1'b1, fr);
      begin
        bit prev = 1'b1;
        int falls = 0, t = 0;
        while (falls < 4 && t < 400) begin
          @(posedge clk); #1;
          if (prev && !ps2_clk_line) falls++;
          prev = ps2_clk_line;
          t++;
        end
        check_eq("rst_fourth_edge", falls, 4);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        dev_abort = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("midreset");
      end
    join
    dev_abort = 1'b0;
    repeat (10) @(posedge clk);
    frame_test(8'hF4, 1'b1, 1'b1, "after_rst", fr);

    // Random bytes and ACK behaviour.
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      bit ack_low, exp_done;
      b = 8'($urandom);
      ack_low = 1'($urandom_range(0, 1));
`ifdef PS2_TX_ACK_CHECK_EN
      exp_done = ack_low;
`else
      exp_done = 1'b1;
`endif
      frame_test(b, ack_low, exp_done, "random", fr);
    end

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
